bist_march_ctrl: RTL and testbench

//  March C- BIST sequencer for the 64-word SRAM. Drives the BIST side of the 6-bit address mux
//  (select + address), the SRAM write/read strobes and the write background. Compares read data

---
 rtl/bist_march_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_bist_march_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bist_march_ctrl.sv
// bist_march_ctrl: March C- BIST sequencer for a 2**ADDR_W word SRAM.
// Runs M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0), M5 up(r0).
// It drives the BIST side of the address mux and the SRAM strobes, and checks each read
// one cycle after it is issued. It reports a sticky fail flag and the first failing address.
// Optional build macro: BIST_ABORT_ON_FAIL_EN. When it is defined, the first mismatch ends the
// run early. When it is undefined, the full march always runs.
module bist_march_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mux_sel,
  output logic [ADDR_W-1:0] bist_addr,
  output logic              bist_we,
  output logic              bist_re,
  output logic [DATA_W-1:0] bist_wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_M0,
    S_M1,
    S_M2,
    S_M3,
    S_M4,
    S_M5,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  // March element properties, kept in one place so the sequencer below stays generic.
  function automatic logic is_march(input state_t s);
    return (s == S_M0) || (s == S_M1) || (s == S_M2) ||
           (s == S_M3) || (s == S_M4) || (s == S_M5);
  endfunction

  // Elements that do a read followed by a write at each address.
  function automatic logic is_rw(input state_t s);
    return (s == S_M1) || (s == S_M2) || (s == S_M3) || (s == S_M4);
  endfunction

  function automatic logic is_down(input state_t s);
    return (s == S_M3) || (s == S_M4);
  endfunction

  // Background expected on reads: M2 and M4 read ones, every other element reads zeros.
  function automatic logic rd_bg(input state_t s);
    return (s == S_M2) || (s == S_M4);
  endfunction

  // Background written: M1 and M3 write ones, M0, M2 and M4 write zeros.
  function automatic logic wr_bg(input state_t s);
    return (s == S_M1) || (s == S_M3);
  endfunction

  function automatic state_t next_elem(input state_t s);
    case (s)
      S_M0:    return S_M1;
      S_M1:    return S_M2;
      S_M2:    return S_M3;
      S_M3:    return S_M4;
      S_M4:    return S_M5;
      default: return S_DRAIN;
    endcase
  endfunction

  // Sequencer state.
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;   // 0 = read cycle A, 1 = write cycle B of an (r,w) pair

  // Compare pipeline: the expected value and the address of the read issued last cycle.
  logic              cmp_valid_q, cmp_valid_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;

  // Registered outputs.
  logic              mux_sel_q, mux_sel_d;
  logic [ADDR_W-1:0] bist_addr_q, bist_addr_d;
  logic              bist_we_q, bist_we_d;
  logic              bist_re_q, bist_re_d;
  logic [DATA_W-1:0] bist_wdata_q, bist_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;

  logic              mismatch;
  logic              abort;
  logic              start_acc;
  logic              elem_last;
  logic              in_march_d;
  logic              wr_op_d;

  // Next-state, compare and output decode. The outputs are decoded from the next state, so
  // each registered output describes the op that the state holds during that cycle.
  always_comb begin
    // NOTE: every signal gets a default before any branch. A path that skips an assignment
    // would otherwise make synthesis infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    phase_d      = phase_q;
    cmp_valid_d  = 1'b0;
    exp_d        = exp_q;
    cmp_addr_d   = cmp_addr_q;
    fail_d       = fail_q;
    fail_addr_d  = fail_addr_q;

    mismatch  = cmp_valid_q && (rdata != exp_q);
`ifdef BIST_ABORT_ON_FAIL_EN
    abort     = mismatch;
`else
    abort     = 1'b0;
`endif
    start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    elem_last = is_down(state_q) ? (addr_q == ADDR_ZERO) : (addr_q == ADDR_MAX);

    // Address and element sequencing.
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc) begin
          state_d = S_M0;
          addr_d  = ADDR_ZERO;
          phase_d = 1'b0;
        end
      end
      S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
        if (abort) begin
          state_d = S_DONE;
          addr_d  = ADDR_ZERO;
          phase_d = 1'b0;
        end else if (is_rw(state_q) && !phase_q) begin
          phase_d = 1'b1;
        end else if (elem_last) begin
          // The next element begins on the very next cycle. Down elements reload from the top.
          state_d = next_elem(state_q);
          addr_d  = is_down(next_elem(state_q)) ? ADDR_MAX : ADDR_ZERO;
          phase_d = 1'b0;
        end else begin
          addr_d  = is_down(state_q) ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
          phase_d = 1'b0;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        addr_d  = ADDR_ZERO;
        phase_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = ADDR_ZERO;
        phase_d = 1'b0;
      end
    endcase

    // Capture the expectation for the read on the bus now. Its data comes back next cycle.
    // A read issued on the abort cycle is never compared.
    if (bist_re_q) begin
      cmp_valid_d = !abort;
      exp_d       = {DATA_W{rd_bg(state_q)}};
      cmp_addr_d  = bist_addr_q;
    end

    // Sticky fail. Only the first mismatch of a run records its address.
    if (start_acc) begin
      fail_d      = 1'b0;
      fail_addr_d = ADDR_ZERO;
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (!fail_q) fail_addr_d = cmp_addr_q;
    end

    // Output decode from the next state.
    in_march_d   = is_march(state_d);
    wr_op_d      = in_march_d && ((state_d == S_M0) || (is_rw(state_d) && phase_d));
    busy_d       = in_march_d || (state_d == S_DRAIN);
    mux_sel_d    = busy_d;
    done_d       = (state_d == S_DONE);
    bist_we_d    = wr_op_d;
    bist_re_d    = in_march_d && !wr_op_d;
    bist_addr_d  = in_march_d ? addr_d : ADDR_ZERO;
    bist_wdata_d = wr_op_d ? {DATA_W{wr_bg(state_d)}} : '0;
  end

  // All state and output registers. Reset is asynchronous, so mux_sel releases the address
  // mux as soon as rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= ADDR_ZERO;
      phase_q      <= 1'b0;
      cmp_valid_q  <= 1'b0;
      exp_q        <= '0;
      cmp_addr_q   <= ADDR_ZERO;
      mux_sel_q    <= 1'b0;
      bist_addr_q  <= ADDR_ZERO;
      bist_we_q    <= 1'b0;
      bist_re_q    <= 1'b0;
      bist_wdata_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_addr_q  <= ADDR_ZERO;
    end else begin
      // NOTE: non-blocking assignments make every register sample the values from before
      // this edge. The order of these lines therefore does not matter.
      state_q      <= state_d;
      addr_q       <= addr_d;
      phase_q      <= phase_d;
      cmp_valid_q  <= cmp_valid_d;
      exp_q        <= exp_d;
      cmp_addr_q   <= cmp_addr_d;
      mux_sel_q    <= mux_sel_d;
      bist_addr_q  <= bist_addr_d;
      bist_we_q    <= bist_we_d;
      bist_re_q    <= bist_re_d;
      bist_wdata_q <= bist_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_addr_q  <= fail_addr_d;
    end
  end

  assign mux_sel    = mux_sel_q;
  assign bist_addr  = bist_addr_q;
  assign bist_we    = bist_we_q;
  assign bist_re    = bist_re_q;
  assign bist_wdata = bist_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign fail_addr  = fail_addr_q;

endmodule

// File: tb/tb_bist_march_ctrl.sv
// tb_bist_march_ctrl: directed bench for bist_march_ctrl with a behavioural 64x8 SRAM.
// The SRAM model supports two faults: stuck-at-1 on bit 0 of one address, and a data flip on
// the Nth read of one address.
// Expectations follow BIST_ABORT_ON_FAIL_EN when the macro is defined.
module tb_bist_march_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mux_sel;
  logic [5:0] bist_addr;
  logic       bist_we;
  logic       bist_re;
  logic [7:0] bist_wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       fail;
  logic [5:0] fail_addr;

  int n_checks = 0;
  int n_errors = 0;

  bist_march_ctrl #(.ADDR_W(6), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mux_sel    (mux_sel),
    .bist_addr  (bist_addr),
    .bist_we    (bist_we),
    .bist_re    (bist_re),
    .bist_wdata (bist_wdata),
    .rdata      (rdata),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_addr  (fail_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model with injectable faults.
  logic [7:0] mem [64];
  int         rd_cnt [64];
  logic       model_clr = 1'b0;
  logic       sa1_en    = 1'b0;
  logic [5:0] sa1_addr  = '0;
  logic       flip_en   = 1'b0;
  logic [5:0] flip_addr = '0;
  int         flip_nth  = 0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'hA5;
    rdata = '0;
  end

  function automatic logic [7:0] model_read(input logic [5:0] a);
    logic [7:0] v;
    v = mem[a];
    if (sa1_en && a == sa1_addr) v[0] = 1'b1;
    if (flip_en && a == flip_addr && rd_cnt[a] == flip_nth - 1) v = ~v;
    return v;
  endfunction

  always @(posedge clk) begin
    if (model_clr) begin
      for (int i = 0; i < 64; i++) rd_cnt[i] <= 0;
    end else begin
      if (bist_we) mem[bist_addr] <= bist_wdata;
      if (bist_re) begin
        rdata             <= model_read(bist_addr);
        rd_cnt[bist_addr] <= rd_cnt[bist_addr] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference March C- op for op index k (0..639), packed as {re, we, addr[5:0], wdata[7:0]}.
  function automatic logic [15:0] exp_op(input int k);
    int         e, j, i;
    logic [5:0] a;
    logic       is_w;
    logic [7:0] wbg;
    if (k < 64) return {1'b0, 1'b1, 6'(k), 8'h00};
    if (k >= 576) return {1'b1, 1'b0, 6'(k - 576), 8'h00};
    e    = (k - 64) / 128 + 1;
    j    = (k - 64) % 128;
    i    = j / 2;
    is_w = (j % 2) == 1;
    a    = (e <= 2) ? 6'(i) : 6'(63 - i);
    wbg  = (e == 1 || e == 3) ? 8'hFF : 8'h00;
    if (is_w) return {1'b0, 1'b1, a, wbg};
    return {1'b1, 1'b0, a, 8'h00};
  endfunction

  // Run one test from IDLE or DONE. c counts cycles after the edge that accepted start.
  task automatic run_march(input string tag, input int restart_cyc, input int rst_cyc,
                           input logic exp_fail, input logic [5:0] exp_faddr,
                           input int exp_done);
    int done_cyc = -1;
    int busy_cnt = 0;
    int both_cnt = 0;
    int late_ops = 0;
    @(negedge clk);
    model_clr = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 700; c++) begin
      start = (c == restart_cyc);
      if (c == 1)
        check({tag, " first cycle busy,mux,done,fail,faddr"},
              {busy, mux_sel, done, fail, fail_addr}, {1'b1, 1'b1, 1'b0, 1'b0, 6'h00});
      if (busy) busy_cnt++;
      if (done && done_cyc < 0) done_cyc = c;
      if (bist_we && bist_re) both_cnt++;
      if (done_cyc >= 0 && (bist_we || bist_re)) late_ops++;
      if (c <= 640 && c < exp_done && done_cyc < 0)
        check($sformatf("%s op c=%0d", tag, c),
              {bist_re, bist_we, bist_addr, bist_wdata}, exp_op(c - 1));
      if (c == 321 && exp_done == 642)
        check({tag, " M3 first op re,addr"}, {bist_re, bist_addr}, {1'b1, 6'd63});
      if (c == 641 && exp_done == 642)
        check({tag, " drain busy,mux,we,re"}, {busy, mux_sel, bist_we, bist_re}, 4'b1100);
      if (c == rst_cyc) begin
        #2 rst = 1'b1;
        #1;
        check({tag, " async reset outputs"},
              {mux_sel, busy, done, fail, fail_addr, bist_we, bist_re, bist_addr, bist_wdata},
              '0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check({tag, " idle after reset busy,done,mux"}, {busy, done, mux_sel}, 3'b000);
        return;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " done cycle"}, done_cyc, exp_done);
    check({tag, " busy cycles"}, busy_cnt, exp_done - 1);
    check({tag, " fail"}, fail, exp_fail);
    check({tag, " fail_addr"}, fail_addr, exp_faddr);
    check({tag, " held done,busy,mux"}, {done, busy, mux_sel}, 3'b100);
    check({tag, " idle addr,wdata"}, {bist_addr, bist_wdata}, '0);
    check({tag, " ops after done"}, late_ops, 0);
    check({tag, " we&re overlap"}, both_cnt, 0);
  endtask

  initial begin
    int sa_done;
    int two_done;
`ifdef BIST_ABORT_ON_FAIL_EN
    sa_done  = 109;
    two_done = 73;
`else
    sa_done  = 642;
    two_done = 642;
`endif
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs",
          {mux_sel, busy, done, fail, fail_addr, bist_we, bist_re, bist_addr, bist_wdata}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("idle no start busy,done", {busy, done}, 2'b00);

    run_march("clean", 0, 0, 1'b0, 6'h00, 642);

    sa1_en   = 1'b1;
    sa1_addr = 6'h15;
    run_march("sa1_15", 0, 0, 1'b1, 6'h15, sa_done);

    sa1_addr  = 6'h03;
    flip_en   = 1'b1;
    flip_addr = 6'h30;
    flip_nth  = 4;
    run_march("two_faults", 30, 0, 1'b1, 6'h03, two_done);

    sa1_en  = 1'b0;
    flip_en = 1'b0;
    run_march("rst_mid", 0, 300, 1'b0, 6'h00, 642);
    run_march("after_rst", 0, 0, 1'b0, 6'h00, 642);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
